// File: rtl/pfd_pkg.sv
// Shared PLL definitions: detector state encoding and the layout and
// encodings of the two-bit status word that feeds the frequency-update logic.
package pfd_pkg;

  // Detector state: no error pulse, link leading, vco leading.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } pfd_state_t;

  // Bit positions inside the status word.
  localparam int SET_ACTIVE = 0;
  localparam int SET_DIR    = 1;

  // Direction encodings carried in setting[SET_DIR].
  localparam logic DIR_RAISE = 1'b0;  // link led: raise the oscillator frequency
  localparam logic DIR_LOWER = 1'b1;  // vco led: lower the oscillator frequency

  // Assemble the status word from its fields.
  function automatic logic [1:0] pack_setting(input logic active, input logic dir);
    logic [1:0] s;
    s             = '0;
    s[SET_ACTIVE] = active;
    s[SET_DIR]    = dir;
    return s;
  endfunction

endpackage

// File: rtl/pfd_edge_sync.sv
// Synchronizer plus rising-edge detector for one asynchronous input.
// The detector is disarmed after reset until the synchronized level has been
// seen low on a genuine post-reset sample. An input that is already high when
// reset is released is therefore not reported until it falls and rises again.
module pfd_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam int MSB = SYNC_STAGES - 1;

  // A chain shorter than two flops gives no metastability protection.
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("pfd_edge_sync: SYNC_STAGES must be at least 2");
  end

  logic [MSB:0] sync_q, sync_d;  // metastability chain, [MSB] is the sync output
  logic [MSB:0] fill_q, fill_d;  // marks which sync stages hold post-reset samples
  logic         hist_q, hist_d;  // sync output delayed by one cycle
  logic         armed_q, armed_d;

  // Next values: shift the chain, track chain fill, remember last level, arm on a seen low.
  always_comb begin
    sync_d  = {sync_q[MSB-1:0], din};
    fill_d  = {fill_q[MSB-1:0], 1'b1};
    hist_d  = sync_q[MSB];
    armed_d = armed_q | (fill_q[MSB] & ~sync_q[MSB]);
  end

  // Synchronizer, history and arming flops; all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      armed_q <= armed_d;
    end
  end

  assign rise = sync_q[MSB] & ~hist_q & armed_q;

endmodule

// File: rtl/pfd.sv
// Synchronous phase-frequency detector. Rising edges of link and vco are
// synchronized with equal latency and drive a three-state machine whose
// registered outputs are the classic up/down pulses plus a status word:
// setting[0] marks the pulse, setting[1] says which input led.
module pfd
  import pfd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link,
  input  logic       vco,
  output logic [1:0] setting,
  output logic       up,
  output logic       dn,
  output logic       upb,
  output logic       dnb
);

  logic       link_rise;
  logic       vco_rise;

  pfd_state_t state_q, state_d;

  logic       up_q, up_d;
  logic       dn_q, dn_d;
  logic       upb_q, upb_d;
  logic       dnb_q, dnb_d;
  logic       act_q, act_d;
  logic       dir_q, dir_d;

  pfd_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_link_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (link),
    .rise (link_rise)
  );

  pfd_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_vco_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (vco),
    .rise (vco_rise)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. The opposite edge always ends a pulse (mutual reset); repeated
  // edges of the leading input saturate; coincident edges in IDLE cancel.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (link_rise && !vco_rise) begin
          state_d = UP;
        end else if (vco_rise && !link_rise) begin
          state_d = DN;
        end
      end
      UP: begin
        if (vco_rise) begin
          state_d = IDLE;
        end
      end
      DN: begin
        if (link_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs move on the
  // same edge as the state. Direction loads only on pulse entry and holds otherwise.
  always_comb begin
    up_d  = (state_d == UP);
    dn_d  = (state_d == DN);
    upb_d = ~up_d;
    dnb_d = ~dn_d;
    act_d = up_d | dn_d;
    dir_d = dir_q;
    if (state_d == UP && state_q != UP) begin
      dir_d = DIR_RAISE;
    end else if (state_d == DN && state_q != DN) begin
      dir_d = DIR_LOWER;
    end
  end

  // Output registers; reset gives idle levels with the complements high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
      upb_q <= 1'b1;
      dnb_q <= 1'b1;
      act_q <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      up_q  <= up_d;
      dn_q  <= dn_d;
      upb_q <= upb_d;
      dnb_q <= dnb_d;
      act_q <= act_d;
      dir_q <= dir_d;
    end
  end

  assign up      = up_q;
  assign dn      = dn_q;
  assign upb     = upb_q;
  assign dnb     = dnb_q;
  assign setting = pack_setting(act_q, dir_q);

endmodule

// File: tb/tb_pfd.sv
// Bench for the phase-frequency detector. Stimulus pushes one record per
// expected error pulse (direction, start cycle, width, period); a monitor on
// the falling clock edge detects pulses on setting[0] and pops/compares them.
module tb_pfd;

  logic       clk;
  logic       rst;
  logic       link;
  logic       vco;
  logic [1:0] setting;
  logic       up;
  logic       dn;
  logic       upb;
  logic       dnb;

  typedef struct {
    logic dir;
    int   start;
    int   width;
    int   period;  // 0 = do not check
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  logic in_pulse = 1'b0;

  pfd #(
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .link    (link),
    .vco     (vco),
    .setting (setting),
    .up      (up),
    .dn      (dn),
    .upb     (upb),
    .dnb     (dnb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic dir, input int start, input int width, input int period);
    exp_t e;
    e.dir    = dir;
    e.start  = start;
    e.width  = width;
    e.period = period;
    q.push_back(e);
  endtask

  // Monitor: structural invariants every cycle, pulse records on setting[0].
  initial begin
    exp_t cur;
    int   width;
    int   last_rise;
    logic unexpected;
    cur.dir = 1'b0; cur.start = 0; cur.width = 0; cur.period = 0;
    width = 0;
    last_rise = 0;
    unexpected = 1'b0;
    forever begin
      @(negedge clk);
      check("complements_and_active",
            {upb, dnb, setting[0], up & dn},
            {~up, ~dn, up | dn, 1'b0});
      if (setting[0] && !in_pulse) begin
        in_pulse = 1'b1;
        width    = 1;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          unexpected = 1'b1;
          $display("FAIL unexpected_pulse: setting=%b at cycle %0d, expected none", setting, cyc);
          cur.dir = setting[1]; cur.start = cyc; cur.width = 0; cur.period = 0;
        end else begin
          unexpected = 1'b0;
          cur = q.pop_front();
          check("pulse_start", cyc, cur.start);
          if (cur.period != 0) check("pulse_period", cyc - last_rise, cur.period);
        end
        last_rise = cyc;
      end else if (setting[0] && in_pulse) begin
        width++;
      end else if (!setting[0] && in_pulse) begin
        in_pulse = 1'b0;
        if (!unexpected) begin
          check("pulse_width", width, cur.width);
          check("setting_after_pulse", setting, {cur.dir, 1'b0});
        end
      end
      if (setting[0] && !unexpected) begin
        check("pulse_outputs", {up, dn, setting[1]}, {~cur.dir, cur.dir, cur.dir});
      end
    end
  end

  // Watchdog: the directed sequence is finite; this only guards a stuck simulation.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int c;
    rst  = 1'b0;
    link = 1'b0;
    vco  = 1'b0;
    #1 rst = 1'b1;
    idle(3);
    check("reset_outputs", {setting, up, dn, upb, dnb}, 6'b00_0011);
    rst = 1'b0;
    idle(6);
    check("idle_after_reset", {setting, up, dn, upb, dnb}, 6'b00_0011);

    // Reset mid-pulse: link starts a pulse, reset lands after 3 pulse cycles.
    c = cyc;
    link = 1'b1;
    expect_pulse(1'b0, c + 3, 3, 0);
    idle(5);
    check("mid_pulse_up", up, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    vco = 1'b1;
    #1;
    check("reset_async_up_upb", {up, upb}, 2'b01);
    check("reset_async_setting", setting, 2'b00);
    idle(3);
    rst = 1'b0;
    // Both inputs held high through release: no pulse may appear.
    idle(20);
    check("no_pulse_held_high", {setting, up, dn}, 4'b0000);
    link = 1'b0;
    vco  = 1'b0;
    idle(6);

    // Link leads by 5 cycles.
    c = cyc;
    link = 1'b1;
    expect_pulse(1'b0, c + 3, 5, 0);
    idle(5);
    vco = 1'b1;
    idle(8);
    check("after_up_pulse", {setting, dn}, 3'b000);
    link = 1'b0;
    vco  = 1'b0;
    idle(6);

    // Vco leads by 7 cycles.
    c = cyc;
    vco = 1'b1;
    expect_pulse(1'b1, c + 3, 7, 0);
    idle(7);
    link = 1'b1;
    idle(8);
    check("after_dn_pulse", setting, 2'b10);
    link = 1'b0;
    vco  = 1'b0;
    idle(6);

    // Simultaneous edges: no pulse, direction bit keeps its value (1).
    link = 1'b1;
    vco  = 1'b1;
    idle(10);
    check("simultaneous_setting", setting, 2'b10);
    link = 1'b0;
    vco  = 1'b0;
    idle(6);

    // Frequency detection: two link edges before one vco edge, one pulse.
    c = cyc;
    link = 1'b1;
    expect_pulse(1'b0, c + 3, 15, 0);
    idle(4);
    link = 1'b0;
    idle(4);
    link = 1'b1;
    idle(7);
    vco = 1'b1;
    idle(6);
    check("freq_detect_done", setting, 2'b00);
    link = 1'b0;
    vco  = 1'b0;
    idle(10);

    // Periodic operation: link period 2500, vco lagging by 100.
    for (int p = 0; p < 3; p++) begin
      c = cyc;
      link = 1'b1;
      expect_pulse(1'b0, c + 3, 100, (p == 0) ? 0 : 2500);
      idle(100);
      vco = 1'b1;
      idle(1000);
      link = 1'b0;
      vco  = 1'b0;
      idle(1400);
    end

    idle(10);
    check("pending_pulses", q.size(), 0);
    check("pulse_open_at_end", in_pulse, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
